serial_sub: RTL

//  Bit-serial subtractor: computes D = X - Y - B_IN one bit per clock, LSB first,

---
 rtl/serial_sub_if.sv | 26 ++
 rtl/serial_sub.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/serial_sub_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The master drives the operands and the result acceptance; the slave drives the result.
interface serial_sub_if #(
    parameter int unsigned W = 8
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         b_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         b_out;
    logic         ovf;

    modport master (
        output in_valid, x, y, b_in, out_ready,
        input  in_ready, out_valid, d, b_out, ovf
    );

    modport slave (
        input  in_valid, x, y, b_in, out_ready,
        output in_ready, out_valid, d, b_out, ovf
    );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: D = X - Y - B_IN computed LSB first, one bit per clock.
// One full-subtractor cell and a borrow flop; results are held until the consumer accepts them.
module serial_sub #(
    parameter int unsigned W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_sub_if.slave bus,
    output logic        busy
);
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [W-1:0]  xs_q, xs_d;
    logic [W-1:0]  ys_q, ys_d;
    logic [W-1:0]  res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          borrow_q, borrow_d;
    logic          x_msb_q, x_msb_d;
    logic          y_msb_q, y_msb_d;

    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic [W-1:0]  d_q, d_d;
    logic          b_out_q, b_out_d;
    logic          ovf_q, ovf_d;

    logic          xi, yi, di, b_next;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Full-subtractor cell on the current LSBs
    always_comb begin
        xi     = xs_q[0];
        yi     = ys_q[0];
        di     = xi ^ yi ^ borrow_q;
        b_next = (~xi & yi) | (~xi & borrow_q) | (yi & borrow_q);
    end

    // Datapath and registered-output next values
    always_comb begin
        xs_d     = xs_q;
        ys_d     = ys_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        x_msb_d  = x_msb_q;
        y_msb_d  = y_msb_q;

        if (state_q == IDLE && bus.in_valid) begin
            xs_d     = bus.x;
            ys_d     = bus.y;
            res_d    = W'(0);
            cnt_d    = CW'(0);
            borrow_d = bus.b_in;
            x_msb_d  = bus.x[W-1];
            y_msb_d  = bus.y[W-1];
        end else if (state_q == RUN) begin
            xs_d     = xs_q >> 1;
            ys_d     = ys_q >> 1;
            // Result bits enter at the MSB so the first (LSB) bit ends at position 0.
            res_d    = (res_q >> 1) | (W'(di) << (W - 1));
            borrow_d = b_next;
            if (cnt_q != LAST) begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == RUN);
        d_d         = W'(0);
        b_out_d     = 1'b0;
        ovf_d       = 1'b0;
        if (state_d == DONE) begin
            d_d     = res_d;
            b_out_d = borrow_d;
            ovf_d   = (x_msb_d ^ y_msb_d) & (res_d[W-1] ^ x_msb_d);
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xs_q        <= W'(0);
            ys_q        <= W'(0);
            res_q       <= W'(0);
            cnt_q       <= CW'(0);
            borrow_q    <= 1'b0;
            x_msb_q     <= 1'b0;
            y_msb_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            d_q         <= W'(0);
            b_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            xs_q        <= xs_d;
            ys_q        <= ys_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            borrow_q    <= borrow_d;
            x_msb_q     <= x_msb_d;
            y_msb_q     <= y_msb_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            d_q         <= d_d;
            b_out_q     <= b_out_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.d         = d_q;
    assign bus.b_out     = b_out_q;
    assign bus.ovf       = ovf_q;
    assign busy          = busy_q;

endmodule
